// File: rtl/chunked_serial_adder.sv
// Multi-cycle N-bit adder/subtractor that works through K bits per clock.
// A registered carry ripples between chunks, least significant chunk first.
// Operands are shifted right after each chunk, so the current chunk always
// sits in the low K bits and no wide read mux is needed.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// RUN   | one chunk per edge, busy=1, sum holds a partial result
// DONE  | result presented, out_valid=1, held until out_ready

module chunked_serial_adder #(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    input  logic         ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         co,
    output logic         busy
);

    localparam int CHUNKS = N / K;
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    // Reject widths that cannot be split into whole chunks.
    if (N < 1 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
        $error("chunked_serial_adder: N must be >= 1 and a multiple of K (1 <= K <= N)");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic          carry;
    logic [CW-1:0] cnt;
    logic [K:0]    chunk_sum;
    logic          accept;
    logic          last_chunk;

    assign chunk_sum = {1'b0, a_reg[K-1:0]} + {1'b0, b_reg[K-1:0]} + {{K{1'b0}}, carry};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        last_chunk = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    last_chunk = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, chunk-by-chunk accumulation and carry-out.
    // sum/co are deliberately not cleared on handoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            co    <= 1'b0;
        end else if (accept) begin
            a_reg <= a0;
            b_reg <= sub ? ~a1 : a1;
            carry <= sub ? 1'b1 : ci;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg                <= a_reg >> K;
            b_reg                <= b_reg >> K;
            carry                <= chunk_sum[K];
            sum[int'(cnt)*K +: K] <= chunk_sum[K-1:0];
            cnt                  <= cnt + CW'(1);
            if (last_chunk) begin
                co <= chunk_sum[K];
            end
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench: directed tests on the default 8/2 instance plus a
// random sweep over several (N,K) shapes, all scored through a queue.

module tb_chunked_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a0 = '0;
    logic [7:0] a1 = '0;
    logic       ci = 1'b0;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum;
    logic       co;
    logic       busy;

    logic        sw_valid = 1'b0;
    logic [11:0] sw_a0 = '0;
    logic [11:0] sw_a1 = '0;
    logic        sw_ci = 1'b0;
    logic        sw_sub = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    localparam int SW_OPS = 24;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    chunked_serial_adder #(.N(8), .K(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a0        (a0),
        .a1        (a1),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: add is A+B+ci; subtract is A-B with co meaning "no borrow".
    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic c, input logic s);
        logic [8:0] r;
        if (s) r = {(a >= b), 8'(a - b)};
        else   r = {1'b0, a} + {1'b0, b} + {8'd0, c};
        return r;
    endfunction

    // Scoreboard for the main instance.
    logic [8:0] exp_q[$];
    logic [8:0] exp_v;
    int         acc_cyc  = 0;
    int         busy_cnt = 0;
    logic       prev_ov  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model8(a0, a1, ci, sub));
                acc_cyc  = cyc + 1;
                busy_cnt = 0;
            end
            if (busy) busy_cnt++;
            if (out_valid && !prev_ov) begin
                check_eq("latency", 32'(cyc - acc_cyc), 32'd4);
                check_eq("busy_len", 32'(busy_cnt), 32'd4);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_result", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_v = exp_q.pop_front();
                    check_eq("result", {23'd0, co, sum}, {23'd0, exp_v});
                end
            end
        end
        prev_ov = out_valid;
    end

    // Sweep instances: shared stimulus, each with its own scoreboard.
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int NN = (g == 0) ? 8 : (g == 1) ? 8 : (g == 2) ? 1 : 12;
        localparam int KK = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 1 : 4;

        logic          rdy, ov, c_o, bsy;
        logic [NN-1:0] s_o;
        logic [NN-1:0] ma, mb;
        logic [NN:0]   e, got_e;
        logic [NN:0]   q[$];
        int            acc  = 0;
        int            done = 0;

        chunked_serial_adder #(.N(NN), .K(KK)) u_sw (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sw_valid),
            .in_ready  (rdy),
            .a0        (sw_a0[NN-1:0]),
            .a1        (sw_a1[NN-1:0]),
            .ci        (sw_ci),
            .sub       (sw_sub),
            .out_valid (ov),
            .out_ready (1'b1),
            .sum       (s_o),
            .co        (c_o),
            .busy      (bsy)
        );

        always @(negedge clk) begin
            if (rst) begin
                q.delete();
            end else begin
                if (sw_valid && rdy) begin
                    ma = sw_a0[NN-1:0];
                    mb = sw_a1[NN-1:0];
                    if (sw_sub) e = {(ma >= mb), NN'(ma - mb)};
                    else        e = {1'b0, ma} + {1'b0, mb} + (NN+1)'(sw_ci);
                    q.push_back(e);
                    acc = cyc + 1;
                end
                if (ov) begin
                    done++;
                    check_eq($sformatf("sweep_lat_n%0d_k%0d", NN, KK), 32'(cyc - acc), 32'(NN / KK));
                    if (q.size() == 0) begin
                        check_eq("sweep_unexpected", 32'(q.size()), 32'd1);
                    end else begin
                        e = q.pop_front();
                        got_e = {c_o, s_o};
                        check_eq($sformatf("sweep_res_n%0d_k%0d", NN, KK), 32'(got_e), 32'(e));
                    end
                end
            end
        end
    end

    // Present operands until the DUT takes them; returns just after the accept edge.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        int n;
        n = 0;
        a0 = a; a1 = b; ci = c; sub = s; in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        if (!out_valid) check_eq("result_timeout", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_co", 32'(co), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Add and carry chains.
        do_op(8'h3C, 8'h0F, 1'b0, 1'b0); wait_result();
        check_eq("add_3c_0f", {23'd0, co, sum}, 32'h04B);
        do_op(8'hFF, 8'h01, 1'b1, 1'b0); wait_result();
        check_eq("chain_ff_01", {23'd0, co, sum}, 32'h101);
        do_op(8'hFF, 8'h00, 1'b1, 1'b0); wait_result();
        check_eq("chain_ff_00", {23'd0, co, sum}, 32'h100);

        // Subtract, ci ignored.
        do_op(8'h10, 8'h03, 1'b1, 1'b1); wait_result();
        check_eq("sub_10_03", {23'd0, co, sum}, 32'h10D);
        do_op(8'h03, 8'h10, 1'b1, 1'b1); wait_result();
        check_eq("sub_03_10", {23'd0, co, sum}, 32'h0F3);

        // Backpressure with competing in_valid.
        out_ready = 1'b0;
        do_op(8'h55, 8'h22, 1'b0, 1'b0);
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!out_valid && n < 50);
            if (!out_valid) check_eq("bp_timeout", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        a0 = 8'h81; a1 = 8'h7F; ci = 1'b1; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_sum", 32'(sum), 32'h77);
            check_eq("bp_co", 32'(co), 32'd0);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("hold_after_handoff", {23'd0, co, sum}, 32'h077);
        check_eq("idle_after_handoff", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result();
        check_eq("after_bp_81_7f", {23'd0, co, sum}, 32'h101);

        // Asynchronous reset in the middle of RUN.
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_sum", 32'(sum), 32'd0);
        check_eq("mid_rst_co", 32'(co), 32'd0);
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        do_op(8'h01, 8'h01, 1'b0, 1'b0); wait_result();
        check_eq("post_rst_01_01", {23'd0, co, sum}, 32'h002);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        // Random sweep across shapes.
        for (int i = 0; i < SW_OPS; i++) begin
            @(posedge clk);
            #1;
            sw_a0 = 12'($urandom);
            sw_a1 = 12'($urandom);
            sw_ci = 1'($urandom);
            sw_sub = 1'($urandom);
            if (i == 0) begin sw_a0 = '1; sw_a1 = 12'd1; sw_ci = 1'b1; sw_sub = 1'b0; end
            if (i == 1) begin sw_a0 = '0; sw_a1 = '1; sw_sub = 1'b1; end
            sw_valid = 1'b1;
            @(posedge clk);
            #1 sw_valid = 1'b0;
            repeat (10) @(posedge clk);
        end
        repeat (2) @(posedge clk);
        check_eq("sweep_done_n8_k8", 32'(g_sw[0].done), 32'(SW_OPS));
        check_eq("sweep_done_n8_k1", 32'(g_sw[1].done), 32'(SW_OPS));
        check_eq("sweep_done_n1_k1", 32'(g_sw[2].done), 32'(SW_OPS));
        check_eq("sweep_done_n12_k4", 32'(g_sw[3].done), 32'(SW_OPS));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
